// File: rtl/uart_pkg.sv
// Shared UART definitions for the 8N1 transmitter/receiver pair.
// Both ends default to the same bit period so they form a loopback pair.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 104;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    STOP     = 3'd3,
    BRK_WAIT = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_8n1_if.sv
// Serial line plus received-byte outputs of the 8N1 receiver.
// slave is the receiver side, master is the line driver / byte consumer.
interface uart_rx_8n1_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] rxbyte;
  logic                 rxdone;
  logic                 rxerr;
  logic                 rxbusy;

  modport master (output rx, input rxbyte, rxdone, rxerr, rxbusy);
  modport slave  (input rx, output rxbyte, rxdone, rxerr, rxbusy);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; 2-cycle latency.
// Reset value is a parameter so idle-high lines come out of reset idle.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle done/error strobes, no buffering.
// rxdone fires 2 + HALF_BIT + 9*CLKS_PER_BIT cycles after the start edge.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_8n1_if.slave  bus
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int IDX_W    = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  uart_state_e          state_q,   state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic [DATA_BITS-1:0] rxbyte_q,  rxbyte_d;
  logic                 rxdone_q,  rxdone_d;
  logic                 rxerr_q,   rxerr_d;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.rx),
    .q_o (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      rxbyte_q  <= '0;
      rxdone_q  <= 1'b0;
      rxerr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rxbyte_q  <= rxbyte_d;
      rxdone_q  <= rxdone_d;
      rxerr_q   <= rxerr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    rxbyte_d  = rxbyte_q;
    rxdone_d  = 1'b0;
    rxerr_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s) state_d = START;
      end

      START: begin
        // Half a bit in: a line back high means the edge was noise.
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
      end

      DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == IDX_LAST) state_d = STOP;
        end
      end

      STOP: begin
        // Leaving mid-stop-bit lets a back-to-back start edge be seen.
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            rxbyte_d = shift_q;
            rxdone_d = 1'b1;
            state_d  = IDLE;
          end else begin
            rxerr_d = 1'b1;
            state_d = BRK_WAIT;
          end
        end
      end

      BRK_WAIT: begin
        clk_cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end

      default: begin
        clk_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  assign bus.rxbyte = rxbyte_q;
  assign bus.rxdone = rxdone_q;
  assign bus.rxerr  = rxerr_q;
  assign bus.rxbusy = (state_q != IDLE);

endmodule

// File: doc/uart_rx_8n1.md
Name: uart_rx_8n1

Overview:
- UART receiver for 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Receive-side counterpart to the team's uart_tx_8n1 transmitter; the same CLKS_PER_BIT setting on both ends gives a loopback pair.
- Sits between an external rx pin and user logic. Delivers each received byte with a one-cycle done strobe and flags framing errors.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per bit period (12 MHz / 115200 baud); must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2, derived local constant; mid-bit sample offset; not overridable.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- rxbyte  output  8  last correctly framed byte; held until the next good frame.
- rxdone  output  1  one-cycle pulse; rxbyte is valid in the same cycle.
- rxerr  output  1  one-cycle pulse on a framing error (stop bit sampled 0).
- rxbusy  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset values: rxbyte=0, rxdone=0, rxerr=0, rxbusy=0, state=IDLE, counters=0.
  - Both synchronizer flops reset to 1 (line idle).
  - Reset wins over every other event, including mid-frame. A frame in progress is dropped with no pulse.
- Input conditioning: rx passes through a 2-flop synchronizer to give rx_s. All decisions use rx_s only (2-cycle latency).
- Bit counter: clk_cnt counts 0..CLKS_PER_BIT-1 and is cleared on every state change. bit_idx counts 0..7.
- States:
  - IDLE: rxbusy=0. If rx_s==0, go to START, clear clk_cnt, set rxbusy=1.
  - START: at clk_cnt==HALF_BIT-1, sample rx_s.
    - If rx_s==1 it was a glitch: go to IDLE with no pulse.
    - Otherwise go to DATA with clk_cnt=0 and bit_idx=0.
  - DATA: at clk_cnt==CLKS_PER_BIT-1, shift rx_s into shift[7] (right shift, LSB first) and increment bit_idx.
    - After the sample with bit_idx==7, go to STOP.
  - STOP: at clk_cnt==CLKS_PER_BIT-1, sample rx_s.
    - If 1: rxbyte<=shift, rxdone=1 for that single cycle, go to IDLE.
    - If 0: rxerr=1 for that single cycle, rxbyte unchanged, go to BRK_WAIT.
  - BRK_WAIT: stay while rx_s==0, so a break condition is a single error. When rx_s==1, go to IDLE.
- Sampling points: every data and stop sample lands at the middle of its bit, i.e. HALF_BIT + k*CLKS_PER_BIT cycles after the synchronized falling edge.
- Latency: rxdone asserts 2 + HALF_BIT + 9*CLKS_PER_BIT cycles (±1) after the raw rx falling edge of the start bit.
- Back-to-back frames: the receiver returns to IDLE in the middle of the stop bit. A new start edge immediately after the stop bit must be caught; no frame gap is required.
- rxdone and rxerr are mutually exclusive and never asserted in consecutive cycles for the same frame.
- No internal FIFO. The user must take rxbyte before the next rxdone, roughly 10 bit periods later.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams: IDLE, START, DATA, STOP, BRK_WAIT;
  - DATA_BITS=8;
  - default CLKS_PER_BIT=104, to be used by both uart_tx_8n1 and uart_rx_8n1.
- One natural sub-module is sync_2ff (parameterizable reset value), reused for any asynchronous input. Everything else stays in a single FSM module.

Test Plan:
- Good byte: with CLKS_PER_BIT=104, drive the 8N1 frame for 0xA5 on rx. Required: one rxdone pulse, rxbyte=0xA5, rxerr never high, latency 2+52+936 cycles (±1).
- Back-to-back: frames 0x00, 0xFF, 0x3C sent with no idle gap. Required: three rxdone pulses exactly 10*104 cycles apart (±1), bytes in order.
- Glitch rejection: drive rx low for 20 cycles, then high. Required: rxbusy pulses and returns to 0, with no rxdone and no rxerr. A following 0x5A frame is then received correctly.
- Framing error / break: send 0x81 with the stop bit low, then hold rx low for 3000 cycles. Required: exactly one rxerr, no rxdone, rxbyte keeps its previous value. After rx returns high, 0x42 is received correctly.
- Reset mid-frame: assert rst for 1 cycle during data bit 4 of 0x99. Required: all outputs 0 the next cycle and no pulse for that frame. The next full frame 0x11 is received correctly.
- Loopback: connect uart_tx_8n1 tx to uart_rx_8n1 rx and send 256 sequential bytes. Required: every rxbyte equals the transmitted byte and rxerr never asserts.
